// File: rtl/operand_fetch.sv
// Register-read stage: holds one decoded instruction, stalls on RAW/WAW against a
// pending-write scoreboard, hands operands to execute. Optional bypass: OPERAND_FETCH_FORWARD_EN.
module operand_fetch #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  output logic               id_ready,
  input  logic [ADDR_W-1:0]  id_rs1,
  input  logic [ADDR_W-1:0]  id_rs2,
  input  logic [ADDR_W-1:0]  id_rd,
  input  logic               id_we,
  output logic [ADDR_W-1:0]  rf_raddr1,
  output logic [ADDR_W-1:0]  rf_raddr2,
  input  logic [DATA_W-1:0]  rf_rdata1,
  input  logic [DATA_W-1:0]  rf_rdata2,
  output logic               ex_valid,
  input  logic               ex_ready,
  output logic [DATA_W-1:0]  ex_op1,
  output logic [DATA_W-1:0]  ex_op2,
  output logic [ADDR_W-1:0]  ex_rd,
  output logic               ex_we,
  input  logic               wb_valid,
  input  logic [ADDR_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0]  wb_data,
  output logic [STALL_W-1:0] stall_cycles
);
  localparam int NREG = 1 << ADDR_W;

  typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_OUT} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [ADDR_W-1:0] rd;
    logic              we;
  } instr_t;

  state_t             r_state, w_next;
  instr_t             r_hold;
  logic [NREG-1:0]    r_busy, w_busy_nxt;
  logic [DATA_W-1:0]  r_op1, r_op2;
  logic [ADDR_W-1:0]  r_ex_rd;
  logic               r_ex_we;
  logic [STALL_W-1:0] r_stall;

  logic               w_accept, w_issue, w_stall, w_hazard;
  logic               w_fwd1, w_fwd2;
  logic [DATA_W-1:0]  w_opnd1, w_opnd2;

`ifdef OPERAND_FETCH_FORWARD_EN
  // A source retiring this cycle is satisfied by the writeback bus.
  assign w_fwd1  = wb_valid && (wb_rd == r_hold.rs1) && (r_hold.rs1 != '0);
  assign w_fwd2  = wb_valid && (wb_rd == r_hold.rs2) && (r_hold.rs2 != '0);
  assign w_opnd1 = (r_hold.rs1 == '0) ? '0 : (w_fwd1 ? wb_data : rf_rdata1);
  assign w_opnd2 = (r_hold.rs2 == '0) ? '0 : (w_fwd2 ? wb_data : rf_rdata2);
`else
  logic w_unused_wb_data;
  assign w_unused_wb_data = ^wb_data;
  assign w_fwd1  = 1'b0;
  assign w_fwd2  = 1'b0;
  assign w_opnd1 = (r_hold.rs1 == '0) ? '0 : rf_rdata1;
  assign w_opnd2 = (r_hold.rs2 == '0) ? '0 : rf_rdata2;
`endif

  // WAW always uses the registered busy bit, even with bypass enabled.
  assign w_hazard = (r_busy[r_hold.rs1] & ~w_fwd1) |
                    (r_busy[r_hold.rs2] & ~w_fwd2) |
                    (r_hold.we & r_busy[r_hold.rd]);

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_issue  = 1'b0;
    w_stall  = 1'b0;
    id_ready = 1'b0;
    case (r_state)
      S_EMPTY: begin
        id_ready = 1'b1;
        if (id_valid) begin
          w_accept = 1'b1;
          w_next   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_hazard) begin
          w_stall = 1'b1;
        end else begin
          w_issue = 1'b1;
          w_next  = S_OUT;
        end
      end
      S_OUT: begin
        id_ready = ex_ready;
        if (ex_ready) begin
          if (id_valid) begin
            w_accept = 1'b1;
            w_next   = S_WAIT;
          end else begin
            w_next = S_EMPTY;
          end
        end
      end
      default: w_next = S_EMPTY;
    endcase
  end

  // Clear first so a same-cycle set on the same register wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_valid) w_busy_nxt[wb_rd] = 1'b0;
    if (w_issue && r_hold.we && (r_hold.rd != '0)) w_busy_nxt[r_hold.rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_EMPTY;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_hold <= '0;
    else if (w_accept) r_hold <= '{rs1: id_rs1, rs2: id_rs2, rd: id_rd, we: id_we};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op1   <= '0;
      r_op2   <= '0;
      r_ex_rd <= '0;
      r_ex_we <= 1'b0;
    end else if (w_issue) begin
      r_op1   <= w_opnd1;
      r_op2   <= w_opnd2;
      r_ex_rd <= r_hold.rd;
      r_ex_we <= r_hold.we;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_stall <= '0;
    else if (w_stall && ~&r_stall)   r_stall <= r_stall + 1'b1;
  end

  assign rf_raddr1    = r_hold.rs1;
  assign rf_raddr2    = r_hold.rs2;
  assign ex_valid     = (r_state == S_OUT);
  assign ex_op1       = r_op1;
  assign ex_op2       = r_op2;
  assign ex_rd        = r_ex_rd;
  assign ex_we        = r_ex_we;
  assign stall_cycles = r_stall;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios plus a randomized run against a
// scoreboard-level model. Define OPERAND_FETCH_FORWARD_EN to match a bypass build.
module tb_operand_fetch;
  localparam int DW = 32, AW = 5, SW = 16, NR = 32;
`ifdef OPERAND_FETCH_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0, rst = 1'b1;
  logic          id_valid = 1'b0, id_ready, id_we = 1'b0;
  logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic [AW-1:0] rf_raddr1, rf_raddr2;
  logic [DW-1:0] rf_rdata1, rf_rdata2;
  logic          ex_valid, ex_ready = 1'b1, ex_we;
  logic [DW-1:0] ex_op1, ex_op2;
  logic [AW-1:0] ex_rd;
  logic          wb_valid = 1'b0;
  logic [AW-1:0] wb_rd = '0;
  logic [DW-1:0] wb_data = '0;
  logic [SW-1:0] stall_cycles;

  int errors = 0, checks = 0;
  logic [DW-1:0] regs [NR];

  always #5 clk = ~clk;

  // Register file: r0 holds all-ones so the stage must force it to zero.
  always @(posedge clk or posedge rst) begin
    if (rst) for (int i = 0; i < NR; i++) regs[i] <= (i == 0) ? '1 : DW'(32'h11 * i);
    else if (wb_valid) regs[wb_rd] <= wb_data;
  end
  assign rf_rdata1 = regs[rf_raddr1];
  assign rf_rdata2 = regs[rf_raddr2];

  operand_fetch #(.DATA_W(DW), .ADDR_W(AW), .STALL_W(SW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_we(id_we),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_rd(ex_rd), .ex_we(ex_we),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall_cycles(stall_cycles)
  );

  // Present an instruction at a negedge; return at the negedge after it is accepted.
  task automatic issue(input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic [AW-1:0] d, input logic w);
    bit done = 1'b0;
    id_valid = 1'b1; id_rs1 = a; id_rs2 = b; id_rd = d; id_we = w;
    for (int k = 0; k < 50 && !done; k++) begin
      #1;
      if (id_ready) done = 1'b1;
      @(negedge clk);
    end
    id_valid = 1'b0;
    checks++;
    if (!done) begin errors++; $display("FAIL issue_timeout: id_ready never 1, required 1"); end
  endtask

  task automatic wb_pulse(input logic [AW-1:0] r, input logic [DW-1:0] dat);
    wb_valid = 1'b1; wb_rd = r; wb_data = dat;
    @(negedge clk);
    wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0; ex_ready = 1'b1;
    issue(5'd0, 5'd0, 5'd5, 1'b1);
    @(negedge clk);
    issue(5'd5, 5'd0, 5'd6, 1'b0);
    @(negedge clk);
    checks++; if (dut.r_busy[5] !== 1'b1) begin errors++; $display("FAIL rst_pre_busy5: got %b need 1", dut.r_busy[5]); end
    checks++; if (stall_cycles !== 16'd1) begin errors++; $display("FAIL rst_pre_stall: got %0d need 1", stall_cycles); end
    #2 rst = 1'b1;
    #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL rst_ex_valid: got %b need 0", ex_valid); end
    checks++; if (dut.r_busy !== 32'd0) begin errors++; $display("FAIL rst_busy: got %h need 0", dut.r_busy); end
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL rst_id_ready: got %b need 1", id_ready); end
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL rst_stall: got %0d need 0", stall_cycles); end
    checks++; if (ex_rd !== 5'd0 || ex_we !== 1'b0 || ex_op1 !== 32'd0 || ex_op2 !== 32'd0) begin
      errors++; $display("FAIL rst_ex_regs: got rd=%0d we=%b op1=%h op2=%h need zeros", ex_rd, ex_we, ex_op1, ex_op2); end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL rst_discard: got ex_valid=%b need 0", ex_valid); end
  endtask

  task automatic test_basic();
    ex_ready = 1'b1;
    issue(5'd1, 5'd2, 5'd3, 1'b1);
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL basic_lat1: got ex_valid=%b need 0", ex_valid); end
    @(negedge clk);
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL basic_lat2: got ex_valid=%b need 1", ex_valid); end
    checks++; if (ex_op1 !== 32'h11 || ex_op2 !== 32'h22) begin
      errors++; $display("FAIL basic_ops: got %h/%h need 00000011/00000022", ex_op1, ex_op2); end
    checks++; if (ex_rd !== 5'd3 || ex_we !== 1'b1) begin errors++; $display("FAIL basic_rd: got %0d/%b need 3/1", ex_rd, ex_we); end
    checks++; if (dut.r_busy[3] !== 1'b1) begin errors++; $display("FAIL basic_busy3: got %b need 1", dut.r_busy[3]); end
    wb_pulse(5'd3, 32'h33);
  endtask

  task automatic test_raw();
    logic [SW-1:0] base;
    ex_ready = 1'b1;
    issue(5'd0, 5'd0, 5'd5, 1'b1);
    issue(5'd5, 5'd0, 5'd6, 1'b0);
    base = stall_cycles;
    repeat (3) @(negedge clk);
    checks++; if (stall_cycles - base !== 16'd3) begin errors++; $display("FAIL raw_stall3: got %0d need 3", stall_cycles - base); end
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL raw_held: got ex_valid=%b need 0", ex_valid); end
    wb_pulse(5'd5, 32'hABCD);
`ifdef OPERAND_FETCH_FORWARD_EN
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL raw_fwd_valid: got %b need 1", ex_valid); end
    checks++; if (ex_op1 !== 32'hABCD) begin errors++; $display("FAIL raw_fwd_op1: got %h need 0000abcd", ex_op1); end
    checks++; if (stall_cycles - base !== 16'd3) begin errors++; $display("FAIL raw_fwd_stall: got %0d need 3", stall_cycles - base); end
`else
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL raw_wb1: got ex_valid=%b need 0", ex_valid); end
    @(negedge clk);
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL raw_wb2: got ex_valid=%b need 1", ex_valid); end
    checks++; if (ex_op1 !== 32'hABCD) begin errors++; $display("FAIL raw_op1: got %h need 0000abcd", ex_op1); end
    checks++; if (stall_cycles - base !== 16'd4) begin errors++; $display("FAIL raw_stall: got %0d need 4", stall_cycles - base); end
`endif
    @(negedge clk);
  endtask

  task automatic test_reg0();
    ex_ready = 1'b1;
    issue(5'd0, 5'd4, 5'd0, 1'b1);
    @(negedge clk);
    checks++; if (ex_valid !== 1'b1 || ex_op1 !== 32'd0) begin
      errors++; $display("FAIL reg0_op1: got valid=%b op1=%h need 1/00000000", ex_valid, ex_op1); end
    checks++; if (ex_op2 !== 32'h44) begin errors++; $display("FAIL reg0_op2: got %h need 00000044", ex_op2); end
    checks++; if (ex_rd !== 5'd0 || ex_we !== 1'b1) begin errors++; $display("FAIL reg0_rd: got %0d/%b need 0/1", ex_rd, ex_we); end
    checks++; if (dut.r_busy !== 32'd0) begin errors++; $display("FAIL reg0_busy: got %h need 0", dut.r_busy); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    ex_ready = 1'b0;
    issue(5'd1, 5'd2, 5'd8, 1'b0);
    @(negedge clk);
    id_valid = 1'b1; id_rs1 = 5'd2; id_rs2 = 5'd1; id_rd = 5'd9; id_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL bp_id_ready[%0d]: got %b need 0", k, id_ready); end
      checks++; if (ex_valid !== 1'b1 || ex_op1 !== 32'h11 || ex_op2 !== 32'h22 || ex_rd !== 5'd8) begin
        errors++; $display("FAIL bp_hold[%0d]: got v=%b %h/%h rd=%0d need 1 00000011/00000022 8", k, ex_valid, ex_op1, ex_op2, ex_rd); end
      @(negedge clk);
    end
    ex_ready = 1'b1;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got id_ready=%b need 1", id_ready); end
    @(negedge clk);
    id_valid = 1'b0;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL bp_next_wait: got ex_valid=%b need 0", ex_valid); end
    @(negedge clk);
    checks++; if (ex_valid !== 1'b1 || ex_op1 !== 32'h22 || ex_op2 !== 32'h11 || ex_rd !== 5'd9) begin
      errors++; $display("FAIL bp_next: got v=%b %h/%h rd=%0d need 1 00000022/00000011 9", ex_valid, ex_op1, ex_op2, ex_rd); end
    @(negedge clk);
  endtask

  task automatic test_waw_setwins();
    ex_ready = 1'b1;
    issue(5'd0, 5'd0, 5'd7, 1'b1);
    wb_pulse(5'd7, 32'h77);
    checks++; if (dut.r_busy[7] !== 1'b1) begin errors++; $display("FAIL waw_setwins: got busy7=%b need 1", dut.r_busy[7]); end
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL waw_first: got ex_valid=%b need 1", ex_valid); end
    issue(5'd0, 5'd0, 5'd7, 1'b1);
    repeat (2) @(negedge clk);
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL waw_stall: got ex_valid=%b need 0", ex_valid); end
    wb_pulse(5'd7, 32'h70);
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL waw_wbcycle: got ex_valid=%b need 0", ex_valid); end
    @(negedge clk);
    checks++; if (ex_valid !== 1'b1 || dut.r_busy[7] !== 1'b1) begin
      errors++; $display("FAIL waw_resume: got v=%b busy7=%b need 1/1", ex_valid, dut.r_busy[7]); end
    @(negedge clk);
  endtask

  // Model: one held instruction issues at the first edge where none of its sources
  // (and, if writing, its destination) has an outstanding write; each blocked cycle is a stall.
  task automatic test_random();
    logic pend = 1'b0, mout = 1'b0, exp_rdy, hz, go;
    logic [AW-1:0] p_rs1 = '0, p_rs2 = '0, p_rd = '0, e_rd = '0, r;
    logic p_we = 1'b0, e_we = 1'b0;
    logic [DW-1:0] e_op1 = '0, e_op2 = '0;
    logic [NR-1:0] mbusy = '0, nb;
    logic [SW-1:0] mstall = '0;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      checks++; if (ex_valid !== mout) begin errors++; $display("FAIL rnd_valid@%0d: got %b need %b", c, ex_valid, mout); end
      if (mout) begin
        checks++; if (ex_op1 !== e_op1 || ex_op2 !== e_op2 || ex_rd !== e_rd || ex_we !== e_we) begin
          errors++; $display("FAIL rnd_out@%0d: got %h/%h rd=%0d we=%b need %h/%h rd=%0d we=%b",
                             c, ex_op1, ex_op2, ex_rd, ex_we, e_op1, e_op2, e_rd, e_we); end
      end
      checks++; if (stall_cycles !== mstall) begin errors++; $display("FAIL rnd_stall@%0d: got %0d need %0d", c, stall_cycles, mstall); end
      checks++; if (dut.r_busy !== mbusy) begin errors++; $display("FAIL rnd_busy@%0d: got %h need %h", c, dut.r_busy, mbusy); end
      id_valid = ($urandom_range(0, 2) != 0);
      id_rs1 = AW'($urandom_range(0, 7)); id_rs2 = AW'($urandom_range(0, 7));
      id_rd = AW'($urandom_range(0, 7)); id_we = 1'($urandom_range(0, 1));
      ex_ready = ($urandom_range(0, 3) != 0);
      wb_valid = ($urandom_range(0, 2) == 0);
      if (mbusy != '0 && $urandom_range(0, 3) != 0) begin
        do r = AW'($urandom_range(0, NR - 1)); while (!mbusy[r]);
      end else r = AW'($urandom_range(0, 7));
      wb_rd = r; wb_data = $urandom;
      #1;
      exp_rdy = !pend && (!mout || ex_ready);
      checks++; if (id_ready !== exp_rdy) begin errors++; $display("FAIL rnd_id_ready@%0d: got %b need %b", c, id_ready, exp_rdy); end
      hz = (mbusy[p_rs1] && !(FWD && wb_valid && wb_rd == p_rs1 && p_rs1 != 0)) ||
           (mbusy[p_rs2] && !(FWD && wb_valid && wb_rd == p_rs2 && p_rs2 != 0)) ||
           (p_we && mbusy[p_rd]);
      go = pend && !hz;
      if (pend && hz && mstall != '1) mstall = mstall + 1'b1;
      if (mout && ex_ready) mout = 1'b0;
      nb = mbusy;
      if (wb_valid) nb[wb_rd] = 1'b0;
      if (go) begin
        e_op1 = (p_rs1 == 0) ? '0 : (FWD && wb_valid && wb_rd == p_rs1) ? wb_data : regs[p_rs1];
        e_op2 = (p_rs2 == 0) ? '0 : (FWD && wb_valid && wb_rd == p_rs2) ? wb_data : regs[p_rs2];
        e_rd = p_rd; e_we = p_we;
        if (p_we && p_rd != 0) nb[p_rd] = 1'b1;
        mout = 1'b1; pend = 1'b0;
      end
      if (exp_rdy && id_valid) begin
        pend = 1'b1; p_rs1 = id_rs1; p_rs2 = id_rs2; p_rd = id_rd; p_we = id_we;
      end
      mbusy = nb;
      @(negedge clk);
    end
    id_valid = 1'b0; wb_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_raw();
    test_reg0();
    test_backpressure();
    test_waw_setwins();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
